divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/divider_if.sv | 24 ++
 rtl/divider.sv | 151 +++++++++++++++
 tb/tb_divider.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/divider_if.sv
// Handshake/data bundle between a divider requester (master) and the divider core (slave).
interface divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             cmd;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             div0;

  modport master (
    output start, cmd, a, b,
    input  busy, done, quot, rem, div0
  );

  modport slave (
    input  start, cmd, a, b,
    output busy, done, quot, rem, div0
  );
endinterface

// File: rtl/divider.sv
// Radix-2 restoring divider, UDIV/SDIV, fixed WIDTH+2 cycle latency.
// Macro DIVIDER_REMAINDER_EN builds the remainder output; otherwise rem is tied to zero.
module divider #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset,
  divider_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dvd_q;     // dividend magnitude, shifts into quotient
  logic [WIDTH-1:0] prem_q;    // partial remainder
  logic [WIDTH-1:0] dvs_q;     // divisor magnitude
  logic             negq_q;
  logic             dz_q;
  logic             busy_q;
  logic             done_q;
  logic             div0_q;
  logic [WIDTH-1:0] quot_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] prem_d;
  logic [WIDTH-1:0] dvd_d;
  logic [WIDTH-1:0] quot_d;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

`ifdef DIVIDER_REMAINDER_EN
  logic [WIDTH-1:0] a_q;
  logic             negr_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] rem_d;
`endif

  assign a_mag = (bus.cmd && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag = (bus.cmd && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // One restoring step: shift in the next dividend bit, keep the subtraction if it did not borrow.
  always_comb begin
    shifted = {prem_q, dvd_q[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, dvs_q};
    prem_d  = shifted[WIDTH-1:0];
    dvd_d   = {dvd_q[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH+1]) begin
      prem_d = diff[WIDTH-1:0];
      dvd_d  = {dvd_q[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    quot_d = negq_q ? -dvd_q : dvd_q;
    if (dz_q) begin
      quot_d = '0;
    end
  end

`ifdef DIVIDER_REMAINDER_EN
  always_comb begin
    rem_d = negr_q ? -prem_q : prem_q;
    if (dz_q) begin
      rem_d = a_q;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      prem_q  <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
      quot_q  <= '0;
`ifdef DIVIDER_REMAINDER_EN
      a_q     <= '0;
      negr_q  <= 1'b0;
      rem_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            dvd_q   <= a_mag;
            dvs_q   <= b_mag;
            prem_q  <= '0;
            cnt_q   <= '0;
            negq_q  <= bus.cmd && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            dz_q    <= (bus.b == '0);
            busy_q  <= 1'b1;
            state_q <= CALC;
`ifdef DIVIDER_REMAINDER_EN
            a_q     <= bus.a;
            negr_q  <= bus.cmd && bus.a[WIDTH-1];
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          prem_q <= prem_d;
          dvd_q  <= dvd_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          quot_q  <= quot_d;
          div0_q  <= dz_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= DONE;
`ifdef DIVIDER_REMAINDER_EN
          rem_q   <= rem_d;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.quot = quot_q;
  assign bus.div0 = div0_q;
`ifdef DIVIDER_REMAINDER_EN
  assign bus.rem  = rem_q;
`else
  assign bus.rem  = '0;
`endif

endmodule

// File: tb/tb_divider.sv
// Randomized self-checking bench for divider against an arithmetic reference model.
module tb_divider;

  localparam int W       = 32;
  localparam int LAT     = W + 2;
  localparam int TIMEOUT = 100;

  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;

  divider_if #(.WIDTH(W)) bus ();

  divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division semantics of UDIV/SDIV.
  task automatic model(input logic c, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic d);
    longint sa, sb, sq, sr;
    if (b == 0) begin
      q = 0; r = a; d = 1'b1;
    end else if (!c) begin
      q = a / b; r = a % b; d = 1'b0;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sq = sa / sb;
      sr = sa % sb;
      q = sq[W-1:0]; r = sr[W-1:0]; d = 1'b0;
    end
`ifndef DIVIDER_REMAINDER_EN
    r = 0;
`endif
  endtask

  // Drive a start at the next edge; returns at the falling edge after the sampling edge.
  task automatic start_op(input logic c, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.cmd = c; bus.a = a; bus.b = b; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.cmd = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input int from, output int lat);
    lat = from;
    while (!bus.done && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic c, input logic [W-1:0] a,
                              input logic [W-1:0] b, input int lat);
    logic [W-1:0] q, r;
    logic d;
    model(c, a, b, q, r, d);
    check({tag, ".lat"},  64'(lat), 64'(LAT));
    check({tag, ".quot"}, 64'(bus.quot), 64'(q));
    check({tag, ".rem"},  64'(bus.rem), 64'(r));
    check({tag, ".div0"}, 64'(bus.div0), 64'(d));
  endtask

  task automatic run_op(input string tag, input logic c, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    start_op(c, a, b);
    check({tag, ".busy"}, 64'(bus.busy), 64'd1);
    wait_done(1, lat);
    check_result(tag, c, a, b, lat);
    check({tag, ".busy_done"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int lat;
    int seen;
    logic [W-1:0] hq, hr;
    logic c;
    logic [W-1:0] ra, rb;

    n_total = 0;
    n_bad   = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.cmd = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    check("rst.busy", 64'(bus.busy), 64'd0);
    check("rst.done", 64'(bus.done), 64'd0);
    check("rst.quot", 64'(bus.quot), 64'd0);
    check("rst.rem",  64'(bus.rem),  64'd0);
    check("rst.div0", 64'(bus.div0), 64'd0);
    reset = 1'b0;

    run_op("udiv_100_7", 1'b0, 32'd100, 32'd7);
    hq = bus.quot; hr = bus.rem;
    repeat (3) @(negedge clk);
    check("hold.done", 64'(bus.done), 64'd0);
    check("hold.quot", 64'(bus.quot), 64'd14);
    check("hold.rem",  64'(bus.rem),  64'(hr));
    run_op("sdiv_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7);
    run_op("udiv_5_0",    1'b0, 32'd5, 32'd0);
    run_op("sdiv_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("sdiv_x_0",    1'b1, 32'h8765_4321, 32'd0);
    run_op("sdiv_7_m2",   1'b1, 32'd7, 32'hFFFF_FFFE);
    run_op("udiv_max_1",  1'b0, 32'hFFFF_FFFF, 32'd1);

    // Start while busy is ignored, then restart in the DONE cycle.
    start_op(1'b0, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    bus.cmd = 1'b0; bus.a = 32'd9; bus.b = 32'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(5, lat);
    check_result("ignore", 1'b0, 32'd100, 32'd7, lat);
    bus.cmd = 1'b0; bus.a = 32'd9; bus.b = 32'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
    check("restart.busy", 64'(bus.busy), 64'd1);
    wait_done(1, lat);
    check_result("restart", 1'b0, 32'd9, 32'd3, lat);

    // Reset in mid-CALC aborts with no done.
    start_op(1'b0, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    check("abort.busy_pre", 64'(bus.busy), 64'd1);
    #1 reset = 1'b1;
    #1;
    check("abort.busy", 64'(bus.busy), 64'd0);
    check("abort.done", 64'(bus.done), 64'd0);
    check("abort.quot", 64'(bus.quot), 64'd0);
    check("abort.rem",  64'(bus.rem),  64'd0);
    check("abort.div0", 64'(bus.div0), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check("abort.no_done", 64'(seen), 64'd0);
    run_op("post_rst_50_5", 1'b0, 32'd50, 32'd5);

    for (int i = 0; i < 50; i++) begin
      c  = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(0, 15));
        1:       rb = -32'($urandom_range(0, 15));
        2:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), c, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
